// File: rtl/game_sequencer_pkg.sv
// Shared encodings and defaults for the game sequencer.
package game_pkg;

   localparam int WIN_SCORE_DEF     = 15;
   localparam int HOLD_FRAMES_DEF   = 90;
   localparam int VALID_TIMEOUT_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RUN        = 3'd1,
      ST_WAIT_VALID = 3'd2,
      ST_POINT_HOLD = 3'd3,
      ST_PAUSED     = 3'd4,
      ST_MATCH_OVER = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2
   } winner_t;

   // Score increment that sticks at the 4-bit ceiling.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Physics-engine step handshake: sequencer requests a step, engine answers once.
interface game_sequencer_if;
   logic       phys_en;
   logic       phys_valid;
   logic       phys_game_over;
   logic [1:0] phys_winner;

   modport master (output phys_en, input phys_valid, phys_game_over, phys_winner);
   modport slave  (input phys_en, output phys_valid, phys_game_over, phys_winner);
endinterface

// File: rtl/game_sequencer_edge_detect.sv
// Rising-edge detector for a debounced level; a held level yields one event.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_rise
);
   logic r_level;

   // Keep one cycle of history of the level.
   always_ff @(posedge clk) begin
      if (rst) r_level <= 1'b0;
      else     r_level <= i_level;
   end

   assign o_rise = i_level & ~r_level;
endmodule

// File: rtl/game_sequencer.sv
// Match/point sequencer wrapped around an external physics engine.
//
//  state       | meaning
//  IDLE        | waiting for a start edge
//  RUN         | live play, one physics step per frame tick
//  WAIT_VALID  | physics step outstanding, timeout running
//  POINT_HOLD  | freeze after a point, counting frame ticks
//  PAUSED      | play suspended until the next pause edge
//  MATCH_OVER  | winner latched until a start edge
module game_sequencer
   import game_pkg::*;
#(
   parameter int WIN_SCORE     = WIN_SCORE_DEF,
   parameter int HOLD_FRAMES   = HOLD_FRAMES_DEF,
   parameter int VALID_TIMEOUT = VALID_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_frame_tick,
   input  logic             i_start_btn,
   input  logic             i_pause_btn,
   game_sequencer_if.master phys,
   output logic             o_ops_en,
   output logic [3:0]       o_score_p1,
   output logic [3:0]       o_score_p2,
   output logic             o_match_over,
   output logic [1:0]       o_match_winner,
   output logic             o_paused,
   output logic             o_sync_fault,
   output logic [2:0]       o_state
);
   localparam logic [3:0] L_WIN  = 4'(WIN_SCORE);
   localparam logic [7:0] L_HOLD = 8'(HOLD_FRAMES);
   localparam logic [7:0] L_TMO  = 8'(VALID_TIMEOUT);

   state_t     r_state;
   logic       r_phys_en;
   logic [3:0] r_score_p1;
   logic [3:0] r_score_p2;
   winner_t    r_match_winner;
   logic       r_sync_fault;
   logic [7:0] r_valid_cnt;
   logic [7:0] r_hold_cnt;

   logic       w_start_rise;
   logic       w_pause_rise;
   logic [3:0] w_p1_inc;
   logic [3:0] w_p2_inc;

   edge_detect u_start_edge (.clk(clk), .rst(rst), .i_level(i_start_btn), .o_rise(w_start_rise));
   edge_detect u_pause_edge (.clk(clk), .rst(rst), .i_level(i_pause_btn), .o_rise(w_pause_rise));

   assign w_p1_inc = sat_inc(r_score_p1);
   assign w_p2_inc = sat_inc(r_score_p2);

   // Sequencing FSM with its timeout and hold down-counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_phys_en      <= 1'b0;
         r_score_p1     <= 4'd0;
         r_score_p2     <= 4'd0;
         r_match_winner <= WIN_NONE;
         r_sync_fault   <= 1'b0;
         r_valid_cnt    <= 8'd0;
         r_hold_cnt     <= 8'd0;
      end else begin
         r_phys_en <= 1'b0;
         // A completion with no request outstanding is a sync error, except in
         // IDLE where it is the leftover of a request abandoned by reset.
         if (phys.phys_valid && r_state != ST_IDLE && r_state != ST_WAIT_VALID)
            r_sync_fault <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_start_rise) begin
                  r_score_p1     <= 4'd0;
                  r_score_p2     <= 4'd0;
                  r_match_winner <= WIN_NONE;
                  r_state        <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (i_frame_tick) begin
                  r_phys_en   <= 1'b1;
                  r_valid_cnt <= L_TMO;
                  r_state     <= ST_WAIT_VALID;
               end else if (w_pause_rise) begin
                  r_state <= ST_PAUSED;
               end
            end
            ST_WAIT_VALID: begin
               if (phys.phys_valid) begin
                  if (!phys.phys_game_over) begin
                     r_state <= ST_RUN;
                  end else if (phys.phys_winner == WIN_P1) begin
                     r_score_p1 <= w_p1_inc;
                     if (w_p1_inc == L_WIN) begin
                        r_match_winner <= WIN_P1;
                        r_state        <= ST_MATCH_OVER;
                     end else begin
                        r_hold_cnt <= L_HOLD;
                        r_state    <= ST_POINT_HOLD;
                     end
                  end else if (phys.phys_winner == WIN_P2) begin
                     r_score_p2 <= w_p2_inc;
                     if (w_p2_inc == L_WIN) begin
                        r_match_winner <= WIN_P2;
                        r_state        <= ST_MATCH_OVER;
                     end else begin
                        r_hold_cnt <= L_HOLD;
                        r_state    <= ST_POINT_HOLD;
                     end
                  end else begin
                     r_sync_fault <= 1'b1;
                     r_state      <= ST_RUN;
                  end
               end else begin
                  // Frame overrun: the step is still pending, so no new request.
                  if (i_frame_tick) r_sync_fault <= 1'b1;
                  if (r_valid_cnt <= 8'd1) begin
                     r_sync_fault <= 1'b1;
                     r_state      <= ST_RUN;
                  end else begin
                     r_valid_cnt <= r_valid_cnt - 8'd1;
                  end
               end
            end
            ST_POINT_HOLD: begin
               if (i_frame_tick) begin
                  if (r_hold_cnt <= 8'd1) begin
                     // Final hold step doubles as the re-serve request.
                     r_phys_en   <= 1'b1;
                     r_valid_cnt <= L_TMO;
                     r_state     <= ST_WAIT_VALID;
                  end else begin
                     r_hold_cnt <= r_hold_cnt - 8'd1;
                  end
               end
            end
            ST_PAUSED: begin
               if (w_pause_rise) r_state <= ST_RUN;
            end
            ST_MATCH_OVER: begin
               if (w_start_rise) begin
                  r_score_p1     <= 4'd0;
                  r_score_p2     <= 4'd0;
                  r_match_winner <= WIN_NONE;
                  r_phys_en      <= 1'b1;
                  r_valid_cnt    <= L_TMO;
                  r_state        <= ST_WAIT_VALID;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign phys.phys_en   = r_phys_en;
   assign o_ops_en       = (r_state == ST_RUN) || (r_state == ST_WAIT_VALID);
   assign o_paused       = (r_state == ST_PAUSED);
   assign o_match_over   = (r_state == ST_MATCH_OVER);
   assign o_score_p1     = r_score_p1;
   assign o_score_p2     = r_score_p2;
   assign o_match_winner = r_match_winner;
   assign o_sync_fault   = r_sync_fault;
   assign o_state        = r_state;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random play, all checked
// every cycle against a behavioural model of the match rules.
module tb_game_sequencer;
   localparam int WIN_SCORE     = 15;
   localparam int HOLD_FRAMES   = 90;
   localparam int VALID_TIMEOUT = 16;

   localparam int S_IDLE = 0, S_RUN = 1, S_WAIT = 2, S_HOLD = 3, S_PAUSED = 4, S_MATCH = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       pause_btn = 1'b0;
   logic       ops_en, match_over, paused, sync_fault;
   logic [3:0] score_p1, score_p2;
   logic [1:0] match_winner;
   logic [2:0] state_o;

   game_sequencer_if u_if ();

   game_sequencer #(
      .WIN_SCORE(WIN_SCORE), .HOLD_FRAMES(HOLD_FRAMES), .VALID_TIMEOUT(VALID_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .i_frame_tick(frame_tick), .i_start_btn(start_btn), .i_pause_btn(pause_btn),
      .phys(u_if),
      .o_ops_en(ops_en), .o_score_p1(score_p1), .o_score_p2(score_p2),
      .o_match_over(match_over), .o_match_winner(match_winner), .o_paused(paused),
      .o_sync_fault(sync_fault), .o_state(state_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int en_count = 0;

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   int m_state = S_IDLE, m_p1 = 0, m_p2 = 0, m_win = 0, m_hold = 0, m_elapsed = 0;
   bit m_en = 0, m_fault = 0, m_sprev = 0, m_pprev = 0;

   always @(posedge clk) begin
      bit se, pe, en;
      int s;
      se = start_btn && !m_sprev;
      pe = pause_btn && !m_pprev;
      en = 0;
      if (rst) begin
         m_state = S_IDLE; m_p1 = 0; m_p2 = 0; m_win = 0; m_hold = 0; m_elapsed = 0;
         m_fault = 0; m_sprev = 0; m_pprev = 0;
      end else begin
         m_sprev = start_btn;
         m_pprev = pause_btn;
         if (u_if.phys_valid && m_state != S_IDLE && m_state != S_WAIT) m_fault = 1;
         case (m_state)
            S_IDLE: if (se) begin m_p1 = 0; m_p2 = 0; m_win = 0; m_state = S_RUN; end
            S_RUN: begin
               if (frame_tick) begin en = 1; m_elapsed = 0; m_state = S_WAIT; end
               else if (pe) m_state = S_PAUSED;
            end
            S_WAIT: begin
               m_elapsed++;
               if (u_if.phys_valid) begin
                  if (!u_if.phys_game_over) m_state = S_RUN;
                  else if (u_if.phys_winner == 1 || u_if.phys_winner == 2) begin
                     s = (u_if.phys_winner == 1) ? m_p1 + 1 : m_p2 + 1;
                     if (s > 15) s = 15;
                     if (u_if.phys_winner == 1) m_p1 = s; else m_p2 = s;
                     if (s == WIN_SCORE) begin m_win = u_if.phys_winner; m_state = S_MATCH; end
                     else begin m_hold = HOLD_FRAMES; m_state = S_HOLD; end
                  end else begin
                     m_fault = 1; m_state = S_RUN;
                  end
               end else begin
                  if (frame_tick) m_fault = 1;
                  if (m_elapsed >= VALID_TIMEOUT) begin m_fault = 1; m_state = S_RUN; end
               end
            end
            S_HOLD: if (frame_tick) begin
               m_hold--;
               if (m_hold == 0) begin en = 1; m_elapsed = 0; m_state = S_WAIT; end
            end
            S_PAUSED: if (pe) m_state = S_RUN;
            S_MATCH: if (se) begin
               m_p1 = 0; m_p2 = 0; m_win = 0; en = 1; m_elapsed = 0; m_state = S_WAIT;
            end
            default: m_state = S_IDLE;
         endcase
      end
      m_en = en;
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      chk("cyc_state", state_o, m_state);
      chk("cyc_phys_en", u_if.phys_en, m_en);
      chk("cyc_ops_en", ops_en, (m_state == S_RUN || m_state == S_WAIT));
      chk("cyc_paused", paused, (m_state == S_PAUSED));
      chk("cyc_match_over", match_over, (m_state == S_MATCH));
      chk("cyc_score_p1", score_p1, m_p1);
      chk("cyc_score_p2", score_p2, m_p2);
      chk("cyc_winner", match_winner, m_win);
      chk("cyc_sync_fault", sync_fault, m_fault);
      if (u_if.phys_en) en_count++;
   end

   // ---------------- stimulus / physics responder ----------------
   int         resp_cnt = 0, resp_delay = 5;
   bit         resp_on = 0, resp_rand = 0, resp_go = 0, spur_on = 0;
   logic [1:0] resp_win = 2'd0;

   task automatic step(input bit tk, input bit st, input bit ps, input bit rs);
      @(posedge clk);
      #1;
      rst = rs; frame_tick = tk; start_btn = st; pause_btn = ps;
      u_if.phys_valid = 1'b0; u_if.phys_game_over = 1'b0; u_if.phys_winner = 2'd0;
      if (resp_on) begin
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               u_if.phys_valid = 1'b1; u_if.phys_game_over = resp_go; u_if.phys_winner = resp_win;
            end
         end
         if (u_if.phys_en) begin
            if (resp_rand) begin
               resp_cnt = $urandom_range(1, 20);
               resp_go  = ($urandom_range(0, 2) == 0);
               resp_win = 2'($urandom_range(0, 3));
            end else resp_cnt = resp_delay;
         end
      end
      if (spur_on && !u_if.phys_valid && $urandom_range(0, 63) == 0) begin
         u_if.phys_valid = 1'b1;
         u_if.phys_game_over = 1'($urandom_range(0, 1));
         u_if.phys_winner = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic run_until(input int st, input int budget, input string name);
      int n = 0;
      while (m_state != st && n < budget) begin step(0, 0, 0, 0); n++; end
      chk(name, state_o, st);
   endtask

   task automatic point(input int who);
      int n = 0;
      resp_go = 1; resp_win = 2'(who); resp_delay = 3;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      while (m_state != S_HOLD && m_state != S_MATCH && n < 50) begin step(0, 0, 0, 0); n++; end
      resp_go = 0;
      if (m_state == S_HOLD) begin
         n = 0;
         while (m_state == S_HOLD && n < 200) begin step(1, 0, 0, 0); n++; end
         run_until(S_RUN, 50, "point_rearm");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit st_lvl, ps_lvl, tk, rs;
      u_if.phys_valid = 1'b0; u_if.phys_game_over = 1'b0; u_if.phys_winner = 2'd0;

      // Reset values
      repeat (3) step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      chk("rst_state", state_o, 0);
      chk("rst_phys_en", u_if.phys_en, 0);
      chk("rst_scores", {score_p1, score_p2}, 0);
      chk("rst_fault", sync_fault, 0);
      chk("rst_ops_en", ops_en, 0);

      // Three plain frame steps, valid 5 cycles after each request
      resp_on = 1; resp_rand = 0; resp_delay = 5; resp_go = 0;
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("start_to_run", state_o, 1);
      base = en_count;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         step(0, 0, 0, 0);
         run_until(S_RUN, 40, "step_back_run");
      end
      chk("three_steps_en", en_count - base, 3);
      chk("three_steps_p1", score_p1, 0);
      chk("three_steps_p2", score_p2, 0);

      // P2 point, hold for 90 ticks, then a single re-serve request
      resp_go = 1; resp_win = 2'd2;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      run_until(S_HOLD, 40, "p2_point_hold");
      chk("p2_point_score", score_p2, 1);
      resp_go = 0;
      base = en_count;
      repeat (89) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("hold_not_early_en", en_count - base, 0);
      chk("hold_not_early_state", state_o, 3);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("hold_end_en", en_count - base, 1);
      chk("hold_end_state", state_o, 2);
      run_until(S_RUN, 40, "hold_back_run");

      // Pause behaviour
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("pause_flag", paused, 1);
      chk("pause_ops_en", ops_en, 0);
      base = en_count;
      repeat (10) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("pause_no_en", en_count - base, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("pause_start_ignored", state_o, 4);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("unpause_run", state_o, 1);
      base = en_count;
      step(1, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("pause_tick_en", en_count - base, 1);
      chk("pause_tick_state", state_o, 2);
      run_until(S_RUN, 40, "pause_tick_back_run");

      // Timeout and frame overrun
      resp_on = 0;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      repeat (15) step(0, 0, 0, 0);
      chk("tmo_still_wait", state_o, 2);
      chk("tmo_no_fault_yet", sync_fault, 0);
      step(0, 0, 0, 0);
      chk("tmo_state", state_o, 1);
      chk("tmo_fault", sync_fault, 1);
      resp_on = 1; resp_delay = 8; resp_go = 0;
      base = en_count;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("overrun_one_en", en_count - base, 1);
      run_until(S_RUN, 40, "overrun_back_run");
      chk("overrun_total_en", en_count - base, 1);

      // P1 wins the match
      for (int i = 0; i < 14; i++) point(1);
      chk("p1_fourteen", score_p1, 14);
      point(1);
      chk("match_over", match_over, 1);
      chk("match_winner", match_winner, 1);
      chk("match_score", score_p1, 15);
      base = en_count;
      repeat (5) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("match_no_en", en_count - base, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("restart_en", en_count - base, 1);
      chk("restart_state", state_o, 2);
      chk("restart_p1", score_p1, 0);
      chk("restart_winner", match_winner, 0);
      run_until(S_RUN, 40, "restart_back_run");

      // Reset during WAIT_VALID, then a late valid
      resp_on = 0;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("rst_mid_wait_pre", state_o, 2);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      u_if.phys_valid = 1'b1; u_if.phys_game_over = 1'b1; u_if.phys_winner = 2'd1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("late_valid_state", state_o, 0);
      chk("late_valid_p1", score_p1, 0);
      chk("late_valid_fault", sync_fault, 0);

      // Random play
      resp_on = 1; resp_rand = 1; spur_on = 1;
      st_lvl = 0; ps_lvl = 0;
      step(0, 1, 0, 0);
      for (int i = 0; i < 6000; i++) begin
         tk = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) st_lvl = !st_lvl;
         if ($urandom_range(0, 11) == 0) ps_lvl = !ps_lvl;
         rs = ($urandom_range(0, 599) == 0);
         step(tk, st_lvl, ps_lvl, rs);
      end
      spur_on = 0; resp_on = 0;
      repeat (3) step(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
